// File: rtl/ds_pkg.sv
// Shared widths, limits and signed types for the delta-sigma modulator.
package ds_pkg;

  localparam int unsigned DATA_W    = 14;
  localparam int unsigned OUT_W     = 4;
  localparam int unsigned ERR_W     = 13;
  localparam int unsigned SUM_W     = 16;
  localparam int unsigned LSB_SHIFT = DATA_W - OUT_W;

  localparam int Q_MAX = 7;
  localparam int Q_MIN = -8;
  localparam int E_MAX = 4095;
  localparam int E_MIN = -4096;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [OUT_W-1:0]  code_t;
  typedef logic signed [ERR_W-1:0]  err_t;
  typedef logic signed [SUM_W-1:0]  sum_t;

endpackage : ds_pkg

// File: rtl/ds_quantizer.sv
// Combinational 16-level quantizer: floor-divides the loop sum by one output
// LSB, clamps the code, and returns the clamped residual for error feedback.
module ds_quantizer
  import ds_pkg::*;
(
  input  logic signed [SUM_W-1:0] u_i,
  output logic signed [OUT_W-1:0] q_c_o,
  output logic signed [ERR_W-1:0] e_c_o
);

  sum_t q_full;
  sum_t e_full;
  code_t q_sat;
  err_t  e_sat;

  // Quantize with saturation, then form and clamp the residual against the saturated code.
  always_comb begin
    q_full = u_i >>> LSB_SHIFT;
    q_sat  = '0;
    if (q_full > sum_t'(Q_MAX)) begin
      q_sat = code_t'(Q_MAX);
    end else if (q_full < sum_t'(Q_MIN)) begin
      q_sat = code_t'(Q_MIN);
    end else begin
      q_sat = code_t'(q_full);
    end

    e_full = u_i - (sum_t'(q_sat) <<< LSB_SHIFT);
    e_sat  = '0;
    if (e_full > sum_t'(E_MAX)) begin
      e_sat = err_t'(E_MAX);
    end else if (e_full < sum_t'(E_MIN)) begin
      e_sat = err_t'(E_MIN);
    end else begin
      e_sat = err_t'(e_full);
    end
  end

  assign q_c_o = q_sat;
  assign e_c_o = e_sat;

endmodule : ds_quantizer

// File: rtl/delta_sigma_mod.sv
// Second-order error-feedback delta-sigma modulator: 14-bit PCM in, 4-bit
// noise-shaped code out, one sample per clock, NTF = (1 - z^-1)^2.
module delta_sigma_mod
  import ds_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] data_in,
  output logic signed [OUT_W-1:0]  data_out
);

  code_t data_out_q, data_out_d;
  err_t  e1_q, e1_d;
  err_t  e2_q, e2_d;
  sum_t  u_c;
  code_t q_c;
  err_t  e_c;

  // Loop sum x + 2*e1 - e2; 16 bits covers the full range without wrap.
  always_comb begin
    u_c = sum_t'(data_in) + (sum_t'(e1_q) <<< 1) - sum_t'(e2_q);
  end

  ds_quantizer u_quant (
    .u_i   (u_c),
    .q_c_o (q_c),
    .e_c_o (e_c)
  );

  // Next-state: new code out, shift the error history.
  always_comb begin
    data_out_d = q_c;
    e2_d       = e1_q;
    e1_d       = e_c;
  end

  // State registers, cleared asynchronously while reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_q <= '0;
      e1_q       <= '0;
      e2_q       <= '0;
    end else begin
      data_out_q <= data_out_d;
      e1_q       <= e1_d;
      e2_q       <= e2_d;
    end
  end

  assign data_out = data_out_q;

endmodule : delta_sigma_mod

// File: tb/tb_delta_sigma_mod.sv
// Directed bench for delta_sigma_mod with hand-computed expected codes.
module tb_delta_sigma_mod;

  logic              clk;
  logic              reset;
  logic signed [13:0] data_in;
  logic signed [3:0]  data_out;

  int n_tests;
  int n_fail;
  int acc;

  delta_sigma_mod dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one sample, clock it in, and leave time 1 after the edge.
  task automatic step(input int x);
    data_in = 14'(x);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    data_in = 14'h1FFF;

    // Reset held with toggling input: output stays 0
    #2;
    for (int i = 0; i < 4; i++) begin
      data_in = (i % 2 == 0) ? 14'h1FFF : 14'h2000;
      @(posedge clk);
      #1;
      check("reset_hold_out", data_out, 0);
    end
    check("reset_hold_e1", dut.e1_q, 0);
    reset = 1'b1;

    // Zero input: silent output, error registers stay 0
    for (int i = 0; i < 4; i++) begin
      step(0);
      check("zero_out", data_out, 0);
    end
    check("zero_e1", dut.e1_q, 0);
    check("zero_e2", dut.e2_q, 0);

    // -1024 is exactly one negative LSB
    for (int i = 0; i < 4; i++) begin
      step(-1024);
      check("neg1_out", data_out, -1);
    end

    // Full-scale negative
    for (int i = 0; i < 4; i++) begin
      step(-8192);
      check("neg8_out", data_out, -8);
    end
    check("neg8_e1", dut.e1_q, 0);

    // Half LSB: period-4 pattern 0,1,1,0 (average 512)
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      step(512);
      check("half_out", data_out, ((i % 4) == 1 || (i % 4) == 2) ? 1 : 0);
      acc += int'(data_out);
    end
    check("half_sum", acc, 4);

    // Async reset between edges mid-stream
    step(512);
    step(512);
    check("pre_async_out", data_out, 1);
    #2;
    reset = 1'b0;
    #1;
    check("async_out", data_out, 0);
    check("async_e1", dut.e1_q, 0);
    check("async_e2", dut.e2_q, 0);
    @(posedge clk);
    #1;
    check("async_hold_out", data_out, 0);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(512);
      check("restart_out", data_out, ((i % 4) == 1 || (i % 4) == 2) ? 1 : 0);
    end

    // Overload: positive full scale pins the code at +7 and e1 at +4095
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      step(8191);
      check("ovl_out", data_out, 7);
    end
    check("ovl_e1", dut.e1_q, 4095);
    check("ovl_e2", dut.e2_q, 4095);

    // Recovery: 3, -3, then settles at 0 with e1 = e2 = 1023
    acc = 0;
    for (int i = 0; i < 64; i++) begin
      step(0);
      acc += int'(data_out);
      if (i < 8) begin
        check("rec_out", data_out, (i == 0) ? 3 : (i == 1) ? -3 : 0);
      end
    end
    check("rec_e1", dut.e1_q, 1023);
    check("rec_avg_bound", ((acc <= 64) && (acc >= -64)) ? 1 : 0, 1);
    check("rec_sum", acc, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_delta_sigma_mod
